sr_ff: RTL and testbench
========================

SR_FF -- requirements
Module: sr_ff

Interface
REQ-001 Parameter WIDTH, default 1: number of independent SR flip-flop bits.
REQ-002 Parameter RESET_VAL, default all-zero: value loaded into q on reset.
REQ-003 Parameter SR11_MODE, default 0: S=R=1 policy; 0 hold, 1 set, 2 clear, 3 toggle.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-low reset.
REQ-006 s  input  WIDTH  per-bit set request.
REQ-007 r  input  WIDTH  per-bit reset (clear) request.
REQ-008 q  output  WIDTH  registered state.
REQ-009 qb  output  WIDTH  complement of q.
REQ-010 err  output  WIDTH  registered flag; bit high for the cycle after s=r=1 was sampled on that bit.
REQ-011 Positional port order SHALL be s, r, clk, reset, q, qb, err, so that existing six-port positional instantiations (s, r, clk, reset, q, qb) remain valid with err left unconnected.

Function
REQ-012 Each bit SHALL update only on the rising edge of clk; no combinational path from s/r to q.
REQ-013 Per bit, with reset=1 at the edge: s=0,r=0 -> q holds; s=1,r=0 -> q=1; s=0,r=1 -> q=0; s=1,r=1 -> per SR11_MODE.
REQ-014 SR11_MODE 3 (toggle) SHALL make q become ~q on each edge with s=r=1 sampled.
REQ-015 SR11_MODE values outside 0..3 SHALL behave as 0 (hold).
REQ-016 qb SHALL equal ~q at all times, including during and after reset; q and qb never equal.
REQ-017 err bit SHALL be 1 exactly one edge after s=r=1 is sampled with reset=1, and 0 otherwise; err is independent of SR11_MODE.
REQ-018 Latency: q reflects s/r sampled at edge N immediately after edge N (one-edge latency); s/r changes between edges have no effect.
REQ-019 Bits SHALL be fully independent; s/r on one bit never affects another.
REQ-020 Driving s=~d, r=d... i.e. s=d, r=~d SHALL yield D-flip-flop behaviour: q equals d sampled at the previous rising edge.

Reset
REQ-021 reset=0 at a rising edge SHALL force q=RESET_VAL, qb=~RESET_VAL, err=0, overriding s and r.
REQ-022 Reset SHALL act only at rising clk edges; asserting reset between edges leaves q unchanged until the next edge.
REQ-023 After reset deasserts, the first edge with reset=1 SHALL apply normal s/r behaviour.
REQ-024 Before the first reset edge q is undefined; no initial value is required.

Structure
REQ-025 SR11_MODE encodings (HOLD=0, SET=1, CLR=2, TOG=3) SHALL be constants in a shared package sr_ff_pkg.
REQ-026 One sub-module sr_ff_bit (single-bit cell with s, r, clk, reset, q, err) SHALL be instantiated WIDTH times via generate; qb derived at top level.

Verification
REQ-027 WIDTH=1, reset=0 for 5 edges with s=1,r=0 -> q=0, qb=1, err=0 throughout.
REQ-028 After reset=1: s=1,r=0 edge -> q=1; s=0,r=0 edge -> q=1; s=0,r=1 edge -> q=0, qb=1.
REQ-029 s=r=1 for one edge from q=1: mode 0 -> q=1; mode 2 -> q=0; mode 3 -> q=0 then q=1 on a second s=r=1 edge; err=1 for one cycle each time.
REQ-030 D-conversion: clk period 20, reset=0 until t=100, d toggling every 4, s=d, r=~d -> q=0 before first edge after t=100, thereafter q equals d at each preceding rising edge, qb=~q.
REQ-031 Mid-operation reset: q=1, pull reset low between edges -> q stays 1 until next edge, then q=RESET_VAL (0).
REQ-032 WIDTH=4, s=4'b0101, r=4'b1010 one edge from reset -> q=4'b0101, qb=4'b1010, err=4'b0000.

Source files
------------

// File: rtl/sr_ff_pkg.sv
// Shared encodings for the SR flip-flop: the S=R=1 policy modes and the
// per-bit next-state rule used by every cell.
package sr_ff_pkg;

  localparam int SR11_HOLD = 0;
  localparam int SR11_SET  = 1;
  localparam int SR11_CLR  = 2;
  localparam int SR11_TOG  = 3;

  typedef enum logic [1:0] {
    CMD_HOLD = 2'b00,
    CMD_CLR  = 2'b01,
    CMD_SET  = 2'b10,
    CMD_BOTH = 2'b11
  } sr_cmd_e;

  // Unknown mode values fall through to hold.
  function automatic logic sr_next(input logic q, input logic s, input logic r,
                                   input int mode);
    sr_cmd_e cmd;
    logic    nxt;
    cmd = sr_cmd_e'({s, r});
    nxt = q;
    case (cmd)
      CMD_SET: nxt = 1'b1;
      CMD_CLR: nxt = 1'b0;
      CMD_BOTH: begin
        case (mode)
          SR11_SET: nxt = 1'b1;
          SR11_CLR: nxt = 1'b0;
          SR11_TOG: nxt = ~q;
          default:  nxt = q;
        endcase
      end
      default: nxt = q;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sr_ff_bit.sv
// Single-bit SR flip-flop cell with synchronous active-low reset and a
// registered flag marking that S and R were both requested.
module sr_ff_bit
  import sr_ff_pkg::*;
#(
  parameter logic RESET_VAL = 1'b0,
  parameter int   SR11_MODE = SR11_HOLD
) (
  input  logic s,
  input  logic r,
  input  logic clk,
  input  logic reset,
  output logic q,
  output logic err
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      q   <= RESET_VAL;
      err <= 1'b0;
    end else begin
      q   <= sr_next(q, s, r, SR11_MODE);
      err <= s & r;
    end
  end

endmodule

// File: rtl/sr_ff.sv
// WIDTH independent SR flip-flops; qb is derived from q so it can never
// disagree with it, including through reset.
module sr_ff
  import sr_ff_pkg::*;
#(
  parameter int               WIDTH     = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               SR11_MODE = SR11_HOLD
) (
  input  logic [WIDTH-1:0] s,
  input  logic [WIDTH-1:0] r,
  input  logic             clk,
  input  logic             reset,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qb,
  output logic [WIDTH-1:0] err
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    sr_ff_bit #(
      .RESET_VAL(RESET_VAL[i]),
      .SR11_MODE(SR11_MODE)
    ) u_bit (
      .s    (s[i]),
      .r    (r[i]),
      .clk  (clk),
      .reset(reset),
      .q    (q[i]),
      .err  (err[i])
    );
  end

  assign qb = ~q;

endmodule

// File: tb/tb_sr_ff.sv
// Scoreboard bench: five 4-bit instances (hold, set, clear, toggle and an
// out-of-range mode) share one stimulus stream; expected values are queued.
module tb_sr_ff;

  logic       clk;
  logic       reset;
  logic [3:0] s;
  logic [3:0] r;

  logic [3:0] q0, qb0, err0;
  logic [3:0] q1, qb1, err1;
  logic [3:0] q2, qb2, err2;
  logic [3:0] q3, qb3, err3;
  logic [3:0] q4, qb4, err4;

  typedef struct {
    string      name;
    logic [3:0] e0;
    logic [3:0] e1;
    logic [3:0] e2;
    logic [3:0] e3;
    logic [3:0] e4;
    logic [3:0] ee;
  } exp_t;

  exp_t sb[$];
  exp_t last_exp;
  int   compared   = 0;
  int   mismatched = 0;

  sr_ff #(.WIDTH(4), .RESET_VAL(4'b0000), .SR11_MODE(0)) u_hold (
    .s(s), .r(r), .clk(clk), .reset(reset), .q(q0), .qb(qb0), .err(err0));
  sr_ff #(.WIDTH(4), .RESET_VAL(4'b1001), .SR11_MODE(1)) u_set (
    .s(s), .r(r), .clk(clk), .reset(reset), .q(q1), .qb(qb1), .err(err1));
  sr_ff #(.WIDTH(4), .RESET_VAL(4'b0000), .SR11_MODE(2)) u_clr (
    .s(s), .r(r), .clk(clk), .reset(reset), .q(q2), .qb(qb2), .err(err2));
  sr_ff #(.WIDTH(4), .RESET_VAL(4'b0000), .SR11_MODE(3)) u_tog (
    .s(s), .r(r), .clk(clk), .reset(reset), .q(q3), .qb(qb3), .err(err3));
  sr_ff #(.WIDTH(4), .RESET_VAL(4'b0000), .SR11_MODE(7)) u_odd (
    .s(s), .r(r), .clk(clk), .reset(reset), .q(q4), .qb(qb4), .err(err4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [3:0] act,
                             input logic [3:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got %b required %b", name, act, exp);
    end
  endtask

  // Inputs glitch to the opposite pattern mid-cycle before settling, so
  // only the value present at the edge may matter.
  task automatic applyStimulus(input string name, input logic rst,
                               input logic [3:0] sv, input logic [3:0] rv,
                               input logic [3:0] e0, input logic [3:0] e1,
                               input logic [3:0] e2, input logic [3:0] e3,
                               input logic [3:0] ee, input bit check_hold);
    exp_t e;
    @(negedge clk);
    s = ~sv;
    r = ~rv;
    #3;
    s     = sv;
    r     = rv;
    reset = rst;
    if (check_hold) begin
      #1;
      checkOutput({name, "_between_edges_hold"}, q0, last_exp.e0);
      checkOutput({name, "_between_edges_set"},  q1, last_exp.e1);
      checkOutput({name, "_between_edges_tog"},  q3, last_exp.e3);
    end
    e.name = name;
    e.e0 = e0; e.e1 = e1; e.e2 = e2; e.e3 = e3; e.e4 = e0; e.ee = ee;
    last_exp = e;
    sb.push_back(e);
    @(posedge clk);
  endtask

  // Monitor: every state change is visible just after the rising edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      checkOutput({e.name, "_q_hold"}, q0, e.e0);
      checkOutput({e.name, "_q_set"},  q1, e.e1);
      checkOutput({e.name, "_q_clr"},  q2, e.e2);
      checkOutput({e.name, "_q_tog"},  q3, e.e3);
      checkOutput({e.name, "_q_odd"},  q4, e.e4);
      checkOutput({e.name, "_qb_hold"}, qb0, ~e.e0);
      checkOutput({e.name, "_qb_set"},  qb1, ~e.e1);
      checkOutput({e.name, "_qb_clr"},  qb2, ~e.e2);
      checkOutput({e.name, "_qb_tog"},  qb3, ~e.e3);
      checkOutput({e.name, "_qb_odd"},  qb4, ~e.e4);
      checkOutput({e.name, "_err_hold"}, err0, e.ee);
      checkOutput({e.name, "_err_set"},  err1, e.ee);
      checkOutput({e.name, "_err_clr"},  err2, e.ee);
      checkOutput({e.name, "_err_tog"},  err3, e.ee);
      checkOutput({e.name, "_err_odd"},  err4, e.ee);
    end
  end

  logic [3:0] dvals [8];

  initial begin
    reset = 1'b0;
    s     = 4'h0;
    r     = 4'h0;
    dvals = '{4'h3, 4'hC, 4'hA, 4'h5, 4'hF, 4'h0, 4'h9, 4'h6};

    for (int i = 0; i < 5; i++)
      applyStimulus("reset_hold", 1'b0, 4'hF, 4'h0,
                    4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    applyStimulus("first_after_reset", 1'b1, 4'b0101, 4'b1010,
                  4'b0101, 4'b0101, 4'b0101, 4'b0101, 4'b0000, 1'b0);
    applyStimulus("set_all", 1'b1, 4'b1111, 4'b0000,
                  4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0);
    applyStimulus("hold_all", 1'b1, 4'b0000, 4'b0000,
                  4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b0000, 1'b0);
    applyStimulus("clear_bit0", 1'b1, 4'b0000, 4'b0001,
                  4'b1110, 4'b1110, 4'b1110, 4'b1110, 4'b0000, 1'b0);
    applyStimulus("both_first", 1'b1, 4'b1111, 4'b1111,
                  4'b1110, 4'b1111, 4'b0000, 4'b0001, 4'b1111, 1'b0);
    applyStimulus("both_second", 1'b1, 4'b1111, 4'b1111,
                  4'b1110, 4'b1111, 4'b0000, 4'b1110, 4'b1111, 1'b0);
    applyStimulus("mixed_bits", 1'b1, 4'b0011, 4'b0101,
                  4'b1010, 4'b1011, 4'b0010, 4'b1011, 4'b0001, 1'b0);
    applyStimulus("hold_after_mixed", 1'b1, 4'b0000, 4'b0000,
                  4'b1010, 4'b1011, 4'b0010, 4'b1011, 4'b0000, 1'b0);
    applyStimulus("mid_op_reset", 1'b0, 4'b1111, 4'b0000,
                  4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b1);
    applyStimulus("both_from_reset", 1'b1, 4'b1111, 4'b1111,
                  4'b0000, 4'b1111, 4'b0000, 4'b1111, 4'b1111, 1'b0);
    applyStimulus("reset_overrides_both", 1'b0, 4'b1111, 4'b1111,
                  4'b0000, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0);

    foreach (dvals[i])
      applyStimulus($sformatf("dff_%0d", i), 1'b1, dvals[i], ~dvals[i],
                    dvals[i], dvals[i], dvals[i], dvals[i], 4'b0000, 1'b0);

    begin
      int budget;
      budget = 5;
      while (sb.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (sb.size() > 0) begin
        mismatched++;
        $display("[TB] FAIL drain: %0d entries left, required 0", sb.size());
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
